register_split: RTL



---
 rtl/register_pkg.sv | 17 +
 rtl/register_hl.sv | 27 ++
 rtl/register_split.sv | 76 +++++++
 3 files changed

// File: rtl/register_pkg.sv
// Shared types for the register_split slice: FSM state encoding and half-width helper.
package register_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_N    = 16;
    localparam int unsigned DEFAULT_HALF = DEFAULT_N / 2;

    function automatic int unsigned half_width(input int unsigned n);
        return n / 2;
    endfunction

endpackage

// File: rtl/register_hl.sv
// High/low hold register: two independently loadable halves sharing one async clear.
module register_hl
    import register_pkg::*;
#(
    parameter int unsigned W = DEFAULT_HALF
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         loadh,
    input  logic         loadl,
    input  logic [W-1:0] inh,
    input  logic [W-1:0] inl,
    output logic [W-1:0] outh,
    output logic [W-1:0] outl
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            outh <= '0;
            outl <= '0;
        end else begin
            if (loadh) outh <= inh;
            if (loadl) outl <= inl;
        end
    end

endmodule

// File: rtl/register_split.sv
// Unloads an N-bit word as two N/2-bit beats, high half first, over a valid/ready port.
// Optional out_last port is enabled by defining REGISTER_SPLIT_LAST_EN.
module register_split
    import register_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic [N-1:0]              in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [half_width(N)-1:0]  out,
    output logic                      out_hsel,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef REGISTER_SPLIT_LAST_EN
    ,
    output logic                      out_last
`endif
);

    localparam int unsigned H = half_width(N);

    state_t       state;
    state_t       state_nxt;
    logic [H-1:0] hold_h;
    logic [H-1:0] hold_l;
    logic         in_hs;
    logic         out_hs;

    register_hl #(.W(H)) u_hold (
        .clk   (clk),
        .clear (clear),
        .loadh (in_hs),
        .loadl (in_hs),
        .inh   (in[N-1:H]),
        .inl   (in[H-1:0]),
        .outh  (hold_h),
        .outl  (hold_l)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // in_ready is the only combinational path from out_ready; it lets LOW refill back-to-back.
    always_comb begin
        in_ready  = (state == IDLE) || ((state == LOW) && out_ready);
        out_valid = (state == HIGH) || (state == LOW);
        out_hsel  = (state == HIGH);
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        out       = '0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_hs) state_nxt = HIGH;
            end
            HIGH: begin
                out = hold_h;
                if (out_hs) state_nxt = LOW;
            end
            LOW: begin
                out = hold_l;
                if (out_hs) state_nxt = in_hs ? HIGH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`ifdef REGISTER_SPLIT_LAST_EN
        out_last = (state == LOW);
`endif
    end

endmodule
